// File: rtl/skaner_pkg.sv
// Shared types and helpers for the bit-scanner: FSM states, index width
// helper and the zero index used when no set bit exists.
package skaner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EMPTY = 2'd2
    } t_stan;

    // Width needed to hold any bit position of a word of the given size.
    function automatic int idx_w(input int bits);
        return $clog2(bits);
    endfunction

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/skaner_bitow_najnizszy_bit.sv
// Combinational lowest-set-bit finder for the residual word of the scanner.
// Reports the position of the lowest 1, whether any bit is set, and whether
// at most one bit is set (so the caller knows this index is the final one).
module najnizszy_bit
    import skaner_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int IDX_W = idx_w(BITS)
) (
    input  logic [BITS-1:0]  residual,
    output logic [IDX_W-1:0] low_idx,
    output logic             any_set,
    output logic             single_set
);

    // Priority search from the top down so the lowest set bit wins last.
    always_comb begin
        low_idx = IDX_W'(ZERO_IDX);
        for (int i = BITS - 1; i >= 0; i--) begin
            if (residual[i]) begin
                low_idx = i[IDX_W-1:0];
            end
        end
    end

    // Population flags: clearing the lowest bit leaves zero only when at
    // most one bit was set.
    always_comb begin
        any_set    = |residual;
        single_set = ((residual & (residual - BITS'(1))) == '0);
    end

endmodule

// File: rtl/skaner_bitow.sv
// Sequential bit scanner: accepts a word and emits the index of each set
// bit, lowest first, one per output handshake. A zero word produces a
// single beat flagged with o_error.
module skaner_bitow
    import skaner_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int IDX_W = idx_w(BITS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_arg_A,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [BITS-1:0] o_index,
    output logic            o_last,
    output logic            o_error,
    output logic            o_valid,
    input  logic            i_ready
);

    t_stan           state_q, state_d;
    logic [BITS-1:0] residual_q, residual_d;

    logic [IDX_W-1:0] low_idx;
    logic             any_set;
    logic             single_set;

    najnizszy_bit #(
        .BITS  (BITS),
        .IDX_W (IDX_W)
    ) u_najnizszy_bit (
        .residual   (residual_q),
        .low_idx    (low_idx),
        .any_set    (any_set),
        .single_set (single_set)
    );

    // Outputs come only from state and residual so they never ripple from
    // the handshake inputs; o_valid depends on state alone.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_index = '0;
        o_last  = 1'b0;
        o_error = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
            end
            SCAN: begin
                o_valid = 1'b1;
                o_index = {{(BITS-IDX_W){1'b0}}, low_idx};
                o_last  = single_set && any_set;
            end
            EMPTY: begin
                o_valid = 1'b1;
                o_last  = 1'b1;
                o_error = 1'b1;
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

    // Next-state logic: load on accept, strip the lowest bit on each output
    // handshake, return to IDLE after the final beat (no same-cycle reload).
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    residual_d = i_arg_A;
                    state_d    = (i_arg_A != '0) ? SCAN : EMPTY;
                end
            end
            SCAN: begin
                if (i_ready) begin
                    residual_d = residual_q & (residual_q - BITS'(1));
                    if (single_set) begin
                        state_d = IDLE;
                    end
                end
            end
            EMPTY: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                residual_d = '0;
            end
        endcase
    end

    // State registers; reset aborts any scan in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            residual_q <= '0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
        end
    end

endmodule
